// File: rtl/axis_frame_rx.sv
// AXI-Stream frame receiver: buffers beats in a FIFO, unpacks them to one sample per
// cycle into FFT memory. Define AXIS_FRAME_RX_STATS_EN for saturating frame/error counters.
module axis_frame_rx #(
    parameter int unsigned SAMPLE_WDT      = 16,
    parameter int unsigned BEAT_SAMPLES    = 2,
    parameter int unsigned FFT_SIZE_LOG2   = 10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [2*SAMPLE_WDT*BEAT_SAMPLES-1:0]  S_AXIS_TDATA,
    input  logic                                  S_AXIS_TLAST,
    input  logic                                  S_AXIS_TVALID,
    output logic                                  S_AXIS_TREADY,
    input  logic                                  cfg_bitrev,
    input  logic                                  comp_busy,
    input  logic                                  m_axis_if_busy,
    output logic [FFT_SIZE_LOG2-1:0]              s_axis_if_addr,
    output logic [SAMPLE_WDT-1:0]                 data_re_0_in,
    output logic [SAMPLE_WDT-1:0]                 data_im_0_in,
    output logic                                  push,
    output logic                                  rx_done,
    output logic                                  rx_err_short,
    output logic                                  rx_err_long,
    output logic                                  s_axis_if_busy
`ifdef AXIS_FRAME_RX_STATS_EN
    ,
    output logic [15:0]                           stat_frame_cnt,
    output logic [15:0]                           stat_err_cnt
`endif
);

    localparam int unsigned TDATA_WDT   = 2 * SAMPLE_WDT * BEAT_SAMPLES;
    localparam int unsigned SMP_W       = 2 * SAMPLE_WDT;
    localparam int unsigned FFT_SIZE    = 1 << FFT_SIZE_LOG2;
    localparam int unsigned FRAME_BEATS = FFT_SIZE / BEAT_SAMPLES;
    localparam int unsigned CNT_W       = FFT_SIZE_LOG2 + 1;
    localparam int unsigned PTR_W       = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH       = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned IDX_W       = (BEAT_SAMPLES > 1) ? $clog2(BEAT_SAMPLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX      = 3'd1,
        DISCARD = 3'd2,
        DRAIN   = 3'd3,
        PAD     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic                   start;
    logic                   fifo_wr;
    logic                   set_long;
    logic                   set_short;
    logic                   pad_push;
    logic                   hs;

    logic [TDATA_WDT-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic                   fifo_empty, fifo_full, full_nxt;

    logic [TDATA_WDT-1:0]   beat_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   unp_active;
    logic                   unp_last;
    logic                   pop;
    logic                   emit;
    logic [SMP_W-1:0]       cur_smp;

    logic [CNT_W-1:0]       n_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   brev_q;
    logic                   tready_nxt;
    logic [FFT_SIZE_LOG2-1:0] wr_addr;

    function automatic logic is_full(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp);
        return (wp[PTR_W-1] != rp[PTR_W-1]) && (wp[PTR_W-2:0] == rp[PTR_W-2:0]);
    endfunction

    function automatic logic [FFT_SIZE_LOG2-1:0] bit_rev(input logic [FFT_SIZE_LOG2-1:0] a);
        logic [FFT_SIZE_LOG2-1:0] r;
        for (int i = 0; i < int'(FFT_SIZE_LOG2); i++) begin
            r[i] = a[int'(FFT_SIZE_LOG2) - 1 - i];
        end
        return r;
    endfunction

    // FIFO status and unpacker handshake
    assign hs         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = is_full(wr_ptr, rd_ptr);
    assign unp_last   = unp_active && (idx_q == IDX_W'(BEAT_SAMPLES - 1));
    assign pop        = !fifo_empty && (!unp_active || unp_last);
    assign emit       = unp_active && (n_q < CNT_W'(FFT_SIZE));
    assign cur_smp    = SMP_W'(beat_q >> (SMP_W * 32'(idx_q)));
    assign wr_addr    = brev_q ? bit_rev(n_q[FFT_SIZE_LOG2-1:0]) : n_q[FFT_SIZE_LOG2-1:0];

    assign wr_ptr_nxt = wr_ptr + PTR_W'(fifo_wr);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    assign full_nxt   = is_full(wr_ptr_nxt, rd_ptr_nxt);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fifo_wr   = 1'b0;
        set_long  = 1'b0;
        set_short = 1'b0;
        pad_push  = 1'b0;
        case (state)
            IDLE: begin
                if (S_AXIS_TVALID && !comp_busy && !m_axis_if_busy) begin
                    state_nxt = RX;
                    start     = 1'b1;
                end
            end
            RX: begin
                if (hs && !fifo_full) begin
                    fifo_wr = 1'b1;
                    if (S_AXIS_TLAST) begin
                        state_nxt = DRAIN;
                    end else if (beat_cnt == CNT_W'(FRAME_BEATS - 1)) begin
                        state_nxt = DISCARD;
                        set_long  = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (hs && S_AXIS_TLAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !unp_active) begin
                    if (n_q < CNT_W'(FFT_SIZE)) begin
                        state_nxt = PAD;
                        set_short = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            PAD: begin
                if (n_q == CNT_W'(FFT_SIZE)) begin
                    state_nxt = DONE;
                end else begin
                    pad_push = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // TREADY is registered, so it is derived from next state and next FIFO occupancy
    assign tready_nxt = ((state_nxt == RX) && !full_nxt) || (state_nxt == DISCARD);

    // Beat storage; contents need no reset
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= S_AXIS_TDATA;
        end
    end

    // FIFO pointers and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            n_q      <= '0;
            brev_q   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (start) begin
                beat_cnt <= '0;
                n_q      <= '0;
                brev_q   <= cfg_bitrev;
            end else begin
                if (fifo_wr) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
                if (emit || pad_push) begin
                    n_q <= n_q + CNT_W'(1);
                end
            end
        end
    end

    // Unpacker: reloads on the last sample of the current beat to avoid bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q     <= '0;
            idx_q      <= '0;
            unp_active <= 1'b0;
        end else if (pop) begin
            beat_q     <= fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
            idx_q      <= '0;
            unp_active <= 1'b1;
        end else if (unp_last) begin
            unp_active <= 1'b0;
        end else if (unp_active) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_AXIS_TREADY  <= 1'b0;
            s_axis_if_busy <= 1'b0;
            rx_done        <= 1'b0;
            push           <= 1'b0;
            s_axis_if_addr <= '0;
            data_re_0_in   <= '0;
            data_im_0_in   <= '0;
            rx_err_short   <= 1'b0;
            rx_err_long    <= 1'b0;
        end else begin
            S_AXIS_TREADY  <= tready_nxt;
            s_axis_if_busy <= (state_nxt != IDLE);
            rx_done        <= (state_nxt == DONE);
            push           <= emit || pad_push;
            if (emit || pad_push) begin
                s_axis_if_addr <= wr_addr;
                data_re_0_in   <= emit ? cur_smp[SMP_W-1:SAMPLE_WDT] : '0;
                data_im_0_in   <= emit ? cur_smp[SAMPLE_WDT-1:0]     : '0;
            end
            if (start) begin
                rx_err_short <= 1'b0;
                rx_err_long  <= 1'b0;
            end else begin
                if (set_short) rx_err_short <= 1'b1;
                if (set_long)  rx_err_long  <= 1'b1;
            end
        end
    end

`ifdef AXIS_FRAME_RX_STATS_EN
    // Saturating statistics, counted as rx_done is raised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frame_cnt <= '0;
            stat_err_cnt   <= '0;
        end else if (state_nxt == DONE) begin
            if (stat_frame_cnt != 16'hFFFF) begin
                stat_frame_cnt <= stat_frame_cnt + 16'd1;
            end
            if ((rx_err_short || rx_err_long) && (stat_err_cnt != 16'hFFFF)) begin
                stat_err_cnt <= stat_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_rx.sv
// Bench for axis_frame_rx: table of directed frames plus random frames against a frame-level model.
module tb_axis_frame_rx;

    localparam int unsigned SW          = 16;
    localparam int unsigned BS          = 2;
    localparam int unsigned LOG2N       = 4;
    localparam int unsigned N           = 1 << LOG2N;
    localparam int unsigned FRAME_BEATS = N / BS;
    localparam int unsigned TW          = 2 * SW * BS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TW-1:0]     S_AXIS_TDATA = '0;
    logic              S_AXIS_TLAST = 1'b0;
    logic              S_AXIS_TVALID = 1'b0;
    logic              S_AXIS_TREADY;
    logic              cfg_bitrev = 1'b0;
    logic              comp_busy = 1'b0;
    logic              m_axis_if_busy = 1'b0;
    logic [LOG2N-1:0]  s_axis_if_addr;
    logic [SW-1:0]     data_re_0_in;
    logic [SW-1:0]     data_im_0_in;
    logic              push;
    logic              rx_done;
    logic              rx_err_short;
    logic              rx_err_long;
    logic              s_axis_if_busy;

    axis_frame_rx #(
        .SAMPLE_WDT      (SW),
        .BEAT_SAMPLES    (BS),
        .FFT_SIZE_LOG2   (LOG2N),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .cfg_bitrev     (cfg_bitrev),
        .comp_busy      (comp_busy),
        .m_axis_if_busy (m_axis_if_busy),
        .s_axis_if_addr (s_axis_if_addr),
        .data_re_0_in   (data_re_0_in),
        .data_im_0_in   (data_im_0_in),
        .push           (push),
        .rx_done        (rx_done),
        .rx_err_short   (rx_err_short),
        .rx_err_long    (rx_err_long),
        .s_axis_if_busy (s_axis_if_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int re;
        int im;
        int cyc;
    } push_t;

    typedef struct {
        int nbeats;
        int brev;
        int gap_max;
        int hold_sel;
        int hold_cyc;
        int data_mode;
        int exp_short;
        int exp_long;
    } vec_t;

    push_t pq[$];
    int    cyc = 0;
    int    done_cnt = 0;
    int    pushes_at_done = 0;
    int    hs_cyc = 0;
    int    stalls = 0;
    int    n_pass = 0;
    int    n_total = 0;
    int    tx_re[64];
    int    tx_im[64];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-write and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (push) begin
            pq.push_back('{int'(s_axis_if_addr), int'(data_re_0_in), int'(data_im_0_in), cyc});
        end
        if (rx_done) begin
            done_cnt++;
            pushes_at_done = pq.size();
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int rev_addr(input int v);
        int r = 0;
        for (int b = 0; b < int'(LOG2N); b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic fill_samples(input int mode, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (mode == 0) begin
                tx_re[i] = i;
                tx_im[i] = 16'h4000 + i;
            end else begin
                tx_re[i] = int'($urandom_range(0, 65535));
                tx_im[i] = int'($urandom_range(0, 65535));
            end
        end
    endtask

    // Drive nbeats beats; TLAST on beat 'last' (-1 for none)
    task automatic drive_frame(input int nbeats, input int last, input int gap_max,
                               input int hold_sel, input int hold_cyc);
        stalls = 0;
        for (int b = 0; b < nbeats; b++) begin
            int gap;
            int w;
            gap = (gap_max > 0 && b > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (gap > 0) begin
                S_AXIS_TVALID = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int k = 0; k < int'(BS); k++) begin
                S_AXIS_TDATA[(2*k)*SW +: SW]   = SW'(tx_im[b*BS + k]);
                S_AXIS_TDATA[(2*k+1)*SW +: SW] = SW'(tx_re[b*BS + k]);
            end
            S_AXIS_TLAST  = (b == last);
            S_AXIS_TVALID = 1'b1;
            if (b == 0 && hold_sel != 0) begin
                int seen = 0;
                if (hold_sel == 1) comp_busy = 1'b1;
                else m_axis_if_busy = 1'b1;
                repeat (hold_cyc) begin
                    @(negedge clk);
                    if (S_AXIS_TREADY || s_axis_if_busy) seen++;
                end
                chk("hold_blocks_start", seen, 0);
                @(posedge clk);
                #1;
                comp_busy      = 1'b0;
                m_axis_if_busy = 1'b0;
            end
            w = 0;
            @(negedge clk);
            while (!S_AXIS_TREADY && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!S_AXIS_TREADY) begin
                chk("beat_accept_timeout", 0, 1);
                break;
            end
            if (b > 0 && w > 0) stalls++;
            if (b == 0) hs_cyc = cyc + 1;
            @(posedge clk);
            #1;
            if (b == 0) cfg_bitrev = ~cfg_bitrev;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    // Frame-level model: first min(beats,N/BS)*BS samples then zeros, in natural/bit-reversed order
    task automatic check_frame(input string tag, input int nbeats, input int brev,
                               input int exp_short, input int exp_long);
        int w = 0;
        int kept;
        while (done_cnt == 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " done_seen"}, int'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        kept = ((nbeats < int'(FRAME_BEATS)) ? nbeats : int'(FRAME_BEATS)) * int'(BS);
        chk({tag, " push_count"}, pq.size(), N);
        for (int i = 0; i < int'(N); i++) begin
            int ea;
            int er;
            int ei;
            ea = (brev != 0) ? rev_addr(i) : i;
            er = (i < kept) ? tx_re[i] : 0;
            ei = (i < kept) ? tx_im[i] : 0;
            if (i < pq.size()) begin
                chk($sformatf("%s push%0d addr", tag, i), pq[i].addr, ea);
                chk($sformatf("%s push%0d re", tag, i), pq[i].re, er);
                chk($sformatf("%s push%0d im", tag, i), pq[i].im, ei);
            end
        end
        if (pq.size() > 0) chk({tag, " first_push_latency"}, pq[0].cyc - hs_cyc, 2);
        chk({tag, " done_once"}, done_cnt, 1);
        chk({tag, " done_after_all_pushes"}, pushes_at_done, N);
        chk({tag, " err_short"}, int'(rx_err_short), exp_short);
        chk({tag, " err_long"}, int'(rx_err_long), exp_long);
        chk({tag, " busy_idle"}, int'(s_axis_if_busy), 0);
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        fill_samples(v.data_mode, v.nbeats * int'(BS));
        pq.delete();
        done_cnt       = 0;
        pushes_at_done = 0;
        cfg_bitrev     = v.brev[0];
        drive_frame(v.nbeats, v.nbeats - 1, v.gap_max, v.hold_sel, v.hold_cyc);
        if (v.gap_max == 0) chk({tag, " no_stall"}, stalls, 0);
        check_frame(tag, v.nbeats, v.brev, v.exp_short, v.exp_long);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{8,  0, 0, 0, 0,  0, 0, 0};
        vecs[1] = '{8,  1, 0, 0, 0,  0, 0, 0};
        vecs[2] = '{5,  0, 0, 0, 0,  0, 1, 0};
        vecs[3] = '{11, 0, 0, 0, 0,  0, 0, 1};
        vecs[4] = '{8,  0, 3, 1, 10, 1, 0, 0};
        vecs[5] = '{1,  1, 0, 2, 6,  1, 1, 0};
        vecs[6] = '{9,  1, 2, 0, 0,  1, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset push", int'(push), 0);
        chk("reset rx_done", int'(rx_done), 0);
        chk("reset tready", int'(S_AXIS_TREADY), 0);
        chk("reset busy", int'(s_axis_if_busy), 0);
        chk("reset err_short", int'(rx_err_short), 0);
        chk("reset err_long", int'(rx_err_long), 0);
        chk("reset addr", int'(s_axis_if_addr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 7; r++) begin
            run_frame($sformatf("vec%0d", r), vecs[r]);
            if (r == 1) begin
                for (int i = 0; i < pq.size(); i++) begin
                    if (pq[i].re == 1)  chk("bitrev sample1", pq[i].addr, 8);
                    if (pq[i].re == 3)  chk("bitrev sample3", pq[i].addr, 12);
                    if (pq[i].re == 15) chk("bitrev sample15", pq[i].addr, 15);
                end
            end
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a frame aborts it silently
        fill_samples(1, 3 * int'(BS));
        pq.delete();
        done_cnt = 0;
        drive_frame(3, -1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset tready", int'(S_AXIS_TREADY), 0);
        chk("midreset busy", int'(s_axis_if_busy), 0);
        chk("midreset push", int'(push), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("aborted no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        run_frame("post_reset", vecs[0]);

        for (int r = 0; r < 10; r++) begin
            vec_t v;
            v.nbeats    = int'($urandom_range(1, 12));
            v.brev      = int'($urandom_range(0, 1));
            v.gap_max   = int'($urandom_range(0, 3));
            v.hold_sel  = int'($urandom_range(0, 2));
            v.hold_cyc  = int'($urandom_range(1, 8));
            v.data_mode = 1;
            v.exp_short = int'(v.nbeats < int'(FRAME_BEATS));
            v.exp_long  = int'(v.nbeats > int'(FRAME_BEATS));
            run_frame($sformatf("rand%0d", r), v);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
